// File: rtl/pc_next_unit_pkg.sv
// Shared core definitions for the fetch PC generator: FSM encoding and default constants.
package pc_next_unit_pkg;

  localparam int unsigned DEFAULT_DATA_W    = 64;
  localparam int unsigned DEFAULT_INC       = 4;
  localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0;
  localparam int unsigned DEFAULT_ALIGN_B   = 2;
  localparam int unsigned CNT_W             = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_unit_adder.sv
// Sequential-fetch increment: next linear PC, wrapping modulo 2^DATA_W.
module pc_adder #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned INC    = 4
) (
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] sum_c
);

  assign sum_c = pc + DATA_W'(INC);

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC generator: boots at RESET_VEC, steps on accepted fetches, takes redirects, halts on misaligned targets.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned       INC       = DEFAULT_INC,
  parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(DEFAULT_RESET_VEC),
  parameter int unsigned       ALIGN_B   = DEFAULT_ALIGN_B
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_redir_valid,
  input  logic [DATA_W-1:0] i_redir_addr,
  input  logic              i_imem_ready,
  output logic [DATA_W-1:0] o_i_addr,
  output logic              o_i_valid,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  // Low target bits that must be zero; ALIGN_B of 0 yields an empty mask.
  localparam logic [DATA_W-1:0] ALIGN_MASK = ~({DATA_W{1'b1}} << ALIGN_B);

  pc_state_e         state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_inc;
  logic              accept;
  logic              redir_misaligned;

  assign accept           = o_i_valid & i_imem_ready & ~i_stall;
  assign redir_misaligned = |(i_redir_addr & ALIGN_MASK);
  assign o_i_addr         = pc;

  pc_adder #(
    .DATA_W(DATA_W),
    .INC   (INC)
  ) u_pc_adder (
    .pc   (pc),
    .sum_c(pc_inc)
  );

  // Redirect wins over everything; o_i_valid mirrors "next state is RUN" so it stays a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      o_i_valid   <= 1'b0;
      o_misalign  <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      if (accept) begin
        o_fetch_cnt <= o_fetch_cnt + CNT_W'(1);
      end
      if (i_redir_valid) begin
        pc <= i_redir_addr;
        if (redir_misaligned) begin
          state      <= ST_HALT;
          o_i_valid  <= 1'b0;
          o_misalign <= 1'b1;
        end else begin
          state      <= ST_RUN;
          o_i_valid  <= 1'b1;
          o_misalign <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_BOOT: begin
            state     <= ST_RUN;
            o_i_valid <= 1'b1;
          end
          ST_RUN: begin
            if (accept) begin
              pc <= pc_inc;
            end
          end
          ST_HALT: begin
            state <= ST_HALT;
          end
          default: begin
            state     <= ST_BOOT;
            o_i_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the width of the program counter and all address ports.
REQ-002 SHALL have parameter INC, default 4, the byte increment applied on each accepted fetch.
REQ-003 SHALL have parameter RESET_VEC, default 0, the first fetch address after reset.
REQ-004 SHALL have parameter ALIGN_B, default 2, the number of low address bits that must be zero for a legal redirect target.
REQ-005 i_clk  input  1  clock, all state updates on the rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_stall  input  1  pipeline stall; holds the PC when high.
REQ-008 i_redir_valid  input  1  branch/jump redirect request this cycle.
REQ-009 i_redir_addr  input  DATA_W  redirect target address.
REQ-010 i_imem_ready  input  1  instruction memory accepts the presented address.
REQ-011 o_i_addr  output  DATA_W  current fetch address (registered PC).
REQ-012 o_i_valid  output  1  o_i_addr is a valid fetch request.
REQ-013 o_misalign  output  1  sticky flag: last redirect target was misaligned.
REQ-014 o_fetch_cnt  output  32  count of accepted fetches since reset, wraps at 2^32.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, HALT; reset state BOOT.
REQ-016 BOOT: o_i_valid=0 for exactly one cycle, o_i_addr=RESET_VEC; unconditional transition to RUN.
REQ-017 RUN: o_i_valid=1; a fetch is accepted when o_i_valid & i_imem_ready & !i_stall.
REQ-018 On an accepted fetch with no redirect, PC SHALL become PC+INC on the next edge, modulo 2^DATA_W (wrap from 2^DATA_W-INC to 0, no flag).
REQ-019 Not accepted (stall or !ready) with no redirect: PC and o_i_valid SHALL hold unchanged.
REQ-020 Redirect priority: i_redir_valid SHALL override stall, ready and increment; PC loads i_redir_addr on the next edge in any state, including BOOT.
REQ-021 Redirect with any of the low ALIGN_B target bits set: PC still loads the target, state -> HALT, o_misalign=1 from the next cycle.
REQ-022 HALT: o_i_valid=0, PC held, no fetch accepted; an aligned redirect SHALL load its target, clear o_misalign and return to RUN next cycle; a misaligned redirect reloads PC and stays in HALT.
REQ-023 Redirect latency: the target SHALL appear on o_i_addr exactly one cycle after i_redir_valid is sampled high.
REQ-024 o_fetch_cnt SHALL increment by 1 per accepted fetch only; redirects and HALT cycles do not count; a redirect in an accepting cycle still counts that fetch.
REQ-025 All outputs SHALL be driven directly from registers; no combinational input-to-output path.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately force state=BOOT, PC=RESET_VEC, o_i_valid=0, o_misalign=0, o_fetch_cnt=0, in any state, including mid-stall or in HALT.
REQ-027 On deassertion, the first rising edge SHALL leave BOOT; the first fetch address presented is RESET_VEC.

Structure
REQ-028 The FSM state encoding (BOOT, RUN, HALT) and the default INC/RESET_VEC constants SHALL live in the shared core package.
REQ-029 The single sub-module pc_adder (DATA_W-wide PC+INC, combinational) SHALL be instantiated for the increment path.

Verification
REQ-030 Reset release with ready=1, no stall -> valid=0 one cycle, then addrs 0x0, 0x4, 0x8; fetch_cnt=3 after three accepts.
REQ-031 In RUN at PC=0x100, stall for 3 cycles -> o_i_addr holds 0x100, fetch_cnt unchanged; on release -> 0x104.
REQ-032 Redirect to 0x2000 while stall=1 -> o_i_addr=0x2000 the next cycle, valid=1, fetch_cnt unchanged.
REQ-033 Redirect to 0x2002 -> HALT, valid=0, misalign=1; then redirect to 0x3000 -> RUN, addr 0x3000, misalign=0.
REQ-034 PC=2^DATA_W-4 accepted -> o_i_addr=0x0 next cycle, valid stays 1.
REQ-035 Assert reset asynchronously mid-cycle in HALT -> outputs reach reset values before the next edge; restart fetches from RESET_VEC.
